// File: rtl/sdram_ls_arbiter.sv
// sdram_ls_arbiter
//   Shares the SDRAM slow-speed (ls) port between three toggle-handshake
//   requesters: ROM loader (32-bit write), backup-RAM load (16-bit write) and
//   backup-RAM save (16-bit read). One transaction in flight at a time,
//   round-robin grant, 16-bit halves steered onto the 32-bit bus by addr[1].
//
//   Build option: SDRAM_LS_ROM_PRIO_EN
//     defined   -> ROM requester has absolute priority; round-robin only
//                  between the two backup requesters.
//     undefined -> plain three-way round-robin ROM -> BKW -> BKR -> ROM.
//
//   Ports
//     clk_sys, reset        clock, synchronous active-high reset
//     rom_req/ack/a/d       ROM write requester (toggle handshake)
//     bkw_req/ack/a/d       backup-load 16-bit write requester
//     bkr_req/ack/a, bkr_q  backup-save 16-bit read requester and its data
//     ls_waddr/din/be       SDRAM ls address, write data, byte enables
//     ls_we_req/ack         SDRAM write toggle pair
//     ls_rd_req/ack, ls_dout SDRAM read toggle pair and read data
module sdram_ls_arbiter #(
  parameter int AW = 25,
  parameter int DW = 32
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          rom_req,
  output logic          rom_ack,
  input  logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_d,
  input  logic          bkw_req,
  output logic          bkw_ack,
  input  logic [AW-1:0] bkw_a,
  input  logic [15:0]   bkw_d,
  input  logic          bkr_req,
  output logic          bkr_ack,
  input  logic [AW-1:0] bkr_a,
  output logic [15:0]   bkr_q,
  output logic [AW-1:0] ls_waddr,
  output logic [DW-1:0] ls_din,
  output logic [3:0]    ls_be,
  output logic          ls_we_req,
  input  logic          ls_we_ack,
  output logic          ls_rd_req,
  input  logic          ls_rd_ack,
  input  logic [DW-1:0] ls_dout
);

  typedef enum logic [1:0] {ST_DRAIN, ST_IDLE, ST_WAIT_W, ST_WAIT_R} state_t;
  typedef enum logic [1:0] {SRC_ROM, SRC_BKW, SRC_BKR} src_t;

  state_t state, state_n;
  src_t   rr_ptr, rr_ptr_n, wr_src, grant;
  logic   grant_vld;
  logic   bkr_hi;
  logic   rom_pend, bkw_pend, bkr_pend;
  logic   we_idle, rd_idle;
  logic   unused_addr_bits;

  assign rom_pend = rom_req != rom_ack;
  assign bkw_pend = bkw_req != bkw_ack;
  assign bkr_pend = bkr_req != bkr_ack;
  assign we_idle  = ls_we_req == ls_we_ack;
  assign rd_idle  = ls_rd_req == ls_rd_ack;

  // Byte/half-word offsets below the bus lane granularity carry no information.
  assign unused_addr_bits = ^{rom_a[1:0], bkw_a[0], bkr_a[0]};

  // Grant selection and the pointer value to adopt if the grant is taken.
  always_comb begin
    grant_vld = 1'b0;
    grant     = SRC_ROM;
    rr_ptr_n  = rr_ptr;
`ifdef SDRAM_LS_ROM_PRIO_EN
    if (rom_pend) begin
      grant_vld = 1'b1; grant = SRC_ROM;
    end else if (rr_ptr == SRC_BKR) begin
      if (bkr_pend)      begin grant_vld = 1'b1; grant = SRC_BKR; end
      else if (bkw_pend) begin grant_vld = 1'b1; grant = SRC_BKW; end
    end else begin
      if (bkw_pend)      begin grant_vld = 1'b1; grant = SRC_BKW; end
      else if (bkr_pend) begin grant_vld = 1'b1; grant = SRC_BKR; end
    end
    // ROM grants leave the pointer alone so the backup pair keeps alternating.
    if (grant_vld && grant == SRC_BKW) rr_ptr_n = SRC_BKR;
    if (grant_vld && grant == SRC_BKR) rr_ptr_n = SRC_BKW;
`else
    case (rr_ptr)
      SRC_BKW: begin
        if (bkw_pend)      begin grant_vld = 1'b1; grant = SRC_BKW; end
        else if (bkr_pend) begin grant_vld = 1'b1; grant = SRC_BKR; end
        else if (rom_pend) begin grant_vld = 1'b1; grant = SRC_ROM; end
      end
      SRC_BKR: begin
        if (bkr_pend)      begin grant_vld = 1'b1; grant = SRC_BKR; end
        else if (rom_pend) begin grant_vld = 1'b1; grant = SRC_ROM; end
        else if (bkw_pend) begin grant_vld = 1'b1; grant = SRC_BKW; end
      end
      default: begin
        if (rom_pend)      begin grant_vld = 1'b1; grant = SRC_ROM; end
        else if (bkw_pend) begin grant_vld = 1'b1; grant = SRC_BKW; end
        else if (bkr_pend) begin grant_vld = 1'b1; grant = SRC_BKR; end
      end
    endcase
    if (grant_vld) begin
      case (grant)
        SRC_ROM: rr_ptr_n = SRC_BKW;
        SRC_BKW: rr_ptr_n = SRC_BKR;
        default: rr_ptr_n = SRC_ROM;
      endcase
    end
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_DRAIN:  if (we_idle && rd_idle) state_n = ST_IDLE;
      ST_IDLE:   if (grant_vld) state_n = (grant == SRC_BKR) ? ST_WAIT_R : ST_WAIT_W;
      ST_WAIT_W: if (we_idle) state_n = ST_IDLE;
      ST_WAIT_R: if (rd_idle) state_n = ST_IDLE;
      default:   state_n = ST_DRAIN;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_DRAIN;
      rr_ptr   <= SRC_ROM;
      wr_src   <= SRC_ROM;
      bkr_hi   <= 1'b0;
      rom_ack  <= 1'b0;
      bkw_ack  <= 1'b0;
      bkr_ack  <= 1'b0;
      bkr_q    <= '0;
      ls_waddr <= '0;
      ls_din   <= '0;
      ls_be    <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            rr_ptr <= rr_ptr_n;
            wr_src <= grant;
            case (grant)
              SRC_ROM: begin
                ls_waddr <= {rom_a[AW-1:2], 2'b00};
                ls_be    <= '1;
                ls_din   <= rom_d;
              end
              SRC_BKW: begin
                ls_waddr <= {bkw_a[AW-1:2], 2'b00};
                if (bkw_a[1]) begin
                  ls_be  <= 4'b1100;
                  ls_din <= {bkw_d, 16'h0000};
                end else begin
                  ls_be  <= 4'b0011;
                  ls_din <= {16'h0000, bkw_d};
                end
              end
              default: begin
                ls_waddr <= {bkr_a[AW-1:2], 2'b00};
                ls_be    <= '1;
                bkr_hi   <= bkr_a[1];
              end
            endcase
          end
        end
        ST_WAIT_W: begin
          if (we_idle) begin
            if (wr_src == SRC_BKW) bkw_ack <= ~bkw_ack;
            else                   rom_ack <= ~rom_ack;
          end
        end
        ST_WAIT_R: begin
          if (rd_idle) begin
            bkr_q   <= bkr_hi ? ls_dout[DW-1:16] : ls_dout[15:0];
            bkr_ack <= ~bkr_ack;
          end
        end
        default: ;
      endcase
    end
  end

  // The SDRAM side is not on this reset, so its request toggles must keep
  // their parity across reset; DRAIN waits for the pairs to rebalance.
  always_ff @(posedge clk_sys) begin
    if (!reset && state == ST_IDLE && grant_vld) begin
      if (grant == SRC_BKR) ls_rd_req <= ~ls_rd_req;
      else                  ls_we_req <= ~ls_we_req;
    end
  end

endmodule

// File: tb/tb_sdram_ls_arbiter.sv
module tb_sdram_ls_arbiter;
  localparam int AW  = 25;
  localparam int LAT = 3;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          rom_req = 1'b0, bkw_req = 1'b0, bkr_req = 1'b0;
  logic          rom_ack, bkw_ack, bkr_ack;
  logic [AW-1:0] rom_a = '0, bkw_a = '0, bkr_a = '0;
  logic [31:0]   rom_d = '0;
  logic [15:0]   bkw_d = '0;
  logic [15:0]   bkr_q;
  logic [AW-1:0] ls_waddr;
  logic [31:0]   ls_din;
  logic [3:0]    ls_be;
  logic          ls_we_req, ls_rd_req;
  logic          ls_we_ack = 1'b0, ls_rd_ack = 1'b0;
  logic [31:0]   ls_dout = '0;

  always #5 clk_sys = ~clk_sys;

  sdram_ls_arbiter #(.AW(AW), .DW(32)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .rom_req(rom_req), .rom_ack(rom_ack), .rom_a(rom_a), .rom_d(rom_d),
    .bkw_req(bkw_req), .bkw_ack(bkw_ack), .bkw_a(bkw_a), .bkw_d(bkw_d),
    .bkr_req(bkr_req), .bkr_ack(bkr_ack), .bkr_a(bkr_a), .bkr_q(bkr_q),
    .ls_waddr(ls_waddr), .ls_din(ls_din), .ls_be(ls_be),
    .ls_we_req(ls_we_req), .ls_we_ack(ls_we_ack),
    .ls_rd_req(ls_rd_req), .ls_rd_ack(ls_rd_ack), .ls_dout(ls_dout)
  );

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   din;
  } ls_exp_t;
  typedef struct {
    int unsigned id;     // 0 ROM, 1 BKW, 2 BKR
    logic [15:0] q;
  } ack_exp_t;

  ls_exp_t  ls_q[$];
  ack_exp_t ack_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ls(input logic rd, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] din);
    ls_exp_t e;
    e.rd = rd; e.addr = a; e.be = be; e.din = din;
    ls_q.push_back(e);
  endtask

  task automatic push_ack(input int unsigned id, input logic [15:0] q);
    ack_exp_t e;
    e.id = id; e.q = q;
    ack_q.push_back(e);
  endtask

  task automatic rom_go(input logic [AW-1:0] a, input logic [31:0] d);
    rom_a = a; rom_d = d; rom_req = ~rom_req;
  endtask
  task automatic bkw_go(input logic [AW-1:0] a, input logic [15:0] d);
    bkw_a = a; bkw_d = d; bkw_req = ~bkw_req;
  endtask
  task automatic bkr_go(input logic [AW-1:0] a);
    bkr_a = a; bkr_req = ~bkr_req;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((rom_req !== rom_ack || bkw_req !== bkw_ack || bkr_req !== bkr_ack) && n < 300) begin
      @(negedge clk_sys); n++;
    end
    check({name, "_done"}, 32'(n < 300), 32'd1);
    repeat (2) @(negedge clk_sys);
    check({name, "_sb_empty"}, 32'(ls_q.size() + ack_q.size()), 32'd0);
  endtask

  // SDRAM model: acknowledges each request LAT cycles after it is seen.
  bit          mdl_en  = 1'b1;
  logic [31:0] rd_data = '0;
  initial begin
    int wcnt = 0;
    int rcnt = 0;
    forever begin
      @(posedge clk_sys); #1;
      if (mdl_en && ls_we_req !== ls_we_ack) begin
        wcnt++;
        if (wcnt >= LAT) begin ls_we_ack = ls_we_req; wcnt = 0; end
      end else wcnt = 0;
      if (mdl_en && ls_rd_req !== ls_rd_ack) begin
        rcnt++;
        if (rcnt >= LAT) begin ls_dout = rd_data; ls_rd_ack = ls_rd_req; rcnt = 0; end
      end else rcnt = 0;
    end
  end

  // Monitor: every SDRAM issue and every requester ack pops a scoreboard entry.
  initial begin
    logic pw, pr, pra, pwa, pba;
    ls_exp_t  e;
    ack_exp_t a;
    int unsigned id;
    @(negedge clk_sys);
    pw = ls_we_req; pr = ls_rd_req; pra = rom_ack; pwa = bkw_ack; pba = bkr_ack;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (ls_we_req !== pw || ls_rd_req !== pr) begin
          if (ls_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL ls_unexpected: got issue at %0t expected none", $time);
          end else begin
            e = ls_q.pop_front();
            check("ls_kind", 32'(ls_rd_req !== pr), 32'(e.rd));
            check("ls_waddr", 32'(ls_waddr), 32'(e.addr));
            check("ls_be", 32'(ls_be), 32'(e.be));
            if (!e.rd) check("ls_din", ls_din, e.din);
          end
        end
        if (rom_ack !== pra || bkw_ack !== pwa || bkr_ack !== pba) begin
          id = (rom_ack !== pra) ? 0 : (bkw_ack !== pwa) ? 1 : 2;
          if (ack_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL ack_unexpected: got ack id %0d expected none", id);
          end else begin
            a = ack_q.pop_front();
            check("ack_order", id, a.id);
            if (id == 2) check("bkr_q", 32'(bkr_q), 32'(a.q));
          end
        end
      end
      pw = ls_we_req; pr = ls_rd_req; pra = rom_ack; pwa = bkw_ack; pba = bkr_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_rom_ack", 32'(rom_ack), 0);
    check("rst_bkw_ack", 32'(bkw_ack), 0);
    check("rst_bkr_ack", 32'(bkr_ack), 0);
    check("rst_bkr_q", 32'(bkr_q), 0);
    check("rst_ls_waddr", 32'(ls_waddr), 0);
    check("rst_ls_din", ls_din, 0);
    check("rst_ls_be", 32'(ls_be), 0);

    // 1: reset while a write is outstanding at the SDRAM
    mdl_en = 1'b0;
    push_ls(1'b0, 25'h000010, 4'b1111, 32'h11111111);
    rom_go(25'h000010, 32'h11111111);
    repeat (3) @(negedge clk_sys);
    check("t1_in_flight", 32'(ls_we_req !== ls_we_ack), 1);
    reset = 1'b1; rom_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    push_ls(1'b0, 25'h000100, 4'b0011, 32'h0000ABCD);
    push_ack(1, '0);
    bkw_go(25'h000100, 16'hABCD);
    repeat (5) @(negedge clk_sys);
    check("t1_drain_hold", 32'(ls_q.size()), 1);
    check("t1_drain_bkw_ack", 32'(bkw_ack), 0);
    mdl_en = 1'b1;
    wait_quiet("t1");
    check("t1_rom_ack_zero", 32'(rom_ack), 0);

    // 2: ROM write with latency checks
    push_ls(1'b0, 25'h100004, 4'b1111, 32'hDEADBEEF);
    push_ack(0, '0);
    rom_go(25'h100004, 32'hDEADBEEF);
    n = 0;
    while (ls_we_req === ls_we_ack && n < 10) begin @(negedge clk_sys); n++; end
    check("t2_issue_lat", n, 1);
    n = 0;
    while (ls_we_req !== ls_we_ack && n < 20) begin @(negedge clk_sys); n++; end
    n = 0;
    while (rom_ack !== rom_req && n < 20) begin @(negedge clk_sys); n++; end
    check("t2_ack_lat", n, 1);
    wait_quiet("t2");

    // 3: BKW lane steering
    push_ls(1'b0, 25'h080000, 4'b1100, 32'h12340000);
    push_ack(1, '0);
    bkw_go(25'h080002, 16'h1234);
    wait_quiet("t3a");
    push_ls(1'b0, 25'h080000, 4'b0011, 32'h00001234);
    push_ack(1, '0);
    bkw_go(25'h080000, 16'h1234);
    wait_quiet("t3b");

    // 4: BKR half selection
    rd_data = 32'hAAAA5555;
    push_ls(1'b1, 25'h080004, 4'b1111, '0);
    push_ack(2, 16'hAAAA);
    bkr_go(25'h080006);
    wait_quiet("t4a");
    push_ls(1'b1, 25'h080004, 4'b1111, '0);
    push_ack(2, 16'h5555);
    bkr_go(25'h080004);
    wait_quiet("t4b");

`ifndef SDRAM_LS_ROM_PRIO_EN
    // 5: simultaneous requests, ROM re-toggles while BKW is in flight
    rd_data = 32'h13572468;
    push_ls(1'b0, 25'h200000, 4'b1111, 32'hCAFEF00D); push_ack(0, '0);
    push_ls(1'b0, 25'h090000, 4'b1100, 32'hBEEF0000); push_ack(1, '0);
    push_ls(1'b1, 25'h090000, 4'b1111, '0);          push_ack(2, 16'h2468);
    push_ls(1'b0, 25'h200008, 4'b1111, 32'h0BADC0DE); push_ack(0, '0);
    rom_go(25'h200000, 32'hCAFEF00D);
    bkw_go(25'h090002, 16'hBEEF);
    bkr_go(25'h090000);
    n = 0;
    while (rom_ack !== rom_req && n < 50) begin @(negedge clk_sys); n++; end
    n = 0;
    while (ls_we_req === ls_we_ack && n < 50) begin @(negedge clk_sys); n++; end
    check("t5_bkw_inflight", 32'(bkw_req !== bkw_ack), 1);
    rom_go(25'h200008, 32'h0BADC0DE);
    wait_quiet("t5");
`else
    // 6: ROM priority with continuous loader traffic
    reset = 1'b1; rom_req = 1'b0; bkw_req = 1'b0; bkr_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    rd_data = 32'hFEDC0123;
    push_ls(1'b0, 25'h300000, 4'b1111, 32'hA0000000); push_ack(0, '0);
    push_ls(1'b0, 25'h300004, 4'b1111, 32'hA0000001); push_ack(0, '0);
    push_ls(1'b0, 25'h300008, 4'b1111, 32'hA0000002); push_ack(0, '0);
    push_ls(1'b0, 25'h30000C, 4'b1111, 32'hA0000003); push_ack(0, '0);
    push_ls(1'b0, 25'h0A0000, 4'b0011, 32'h00005A5A); push_ack(1, '0);
    push_ls(1'b1, 25'h0A0000, 4'b1111, '0);          push_ack(2, 16'hFEDC);
    rom_go(25'h300000, 32'hA0000000);
    bkw_go(25'h0A0000, 16'h5A5A);
    bkr_go(25'h0A0002);
    for (int k = 1; k < 4; k++) begin
      n = 0;
      while (rom_ack !== rom_req && n < 50) begin @(negedge clk_sys); n++; end
      check("t6_rom_turn", 32'(n < 50), 1);
      rom_go(25'h300000 + 25'(4 * k), 32'hA0000000 + 32'(k));
    end
    wait_quiet("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
